square_drawer: RTL

Requester-side partner of the square location picker. On a `go` pulse it requests a random top-left corner over the start/done handshake, latches the returned coordinates, then walks a SIZE×SIZE square and emits one pixel write per in-bounds pixel to the VGA framebuffer writer, with back-pressure. It sits between the game control FSM and the framebuffer write port.

---
 rtl/square_drawer.sv | 120 ++++++++++++
 1 files changed

// File: rtl/square_drawer.sv
//------------------------------------------------------------------------------
// Module   : square_drawer
// Function : Requests a random corner from the location picker, then walks a
//            SIZE x SIZE square emitting one clipped pixel write per pixel.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module square_drawer #(
  parameter int SIZE     = 20,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        go,
  input  logic        color_in,
  output logic        loc_start,
  input  logic        loc_done,
  input  logic [10:0] loc_x,
  input  logic [10:0] loc_y,
  output logic [10:0] pix_x,
  output logic [10:0] pix_y,
  output logic        pix_color,
  output logic        pix_wr,
  input  logic        pix_ready,
  output logic        busy,
  output logic        done
);

  localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(SIZE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DRAW = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cx;
  logic [CW-1:0] r_cy;
  logic [10:0]   r_base_x;
  logic [10:0]   r_base_y;
  logic          r_color;
  logic [11:0]   w_sum_x;
  logic [11:0]   w_sum_y;
  logic          w_in_bounds;
  logic          w_advance;
  logic          w_last_col;
  logic          w_last_row;

  // Sums kept one bit wider so a square hanging off the right/bottom edge clips
  assign w_sum_x     = {1'b0, r_base_x} + 12'(r_cx);
  assign w_sum_y     = {1'b0, r_base_y} + 12'(r_cy);
  assign w_in_bounds = (w_sum_x < 12'(SCREEN_W)) && (w_sum_y < 12'(SCREEN_H));
  assign w_last_col  = (r_cx == C_LAST);
  assign w_last_row  = (r_cy == C_LAST);
  assign w_advance   = (r_state == S_DRAW) && (pix_ready || !w_in_bounds);

  assign pix_x     = w_sum_x[10:0];
  assign pix_y     = w_sum_y[10:0];
  assign pix_color = r_color;
  assign pix_wr    = (r_state == S_DRAW) && w_in_bounds;
  assign loc_start = (r_state == S_REQ);
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_FIN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (go) w_next = S_REQ;
      S_REQ:   if (loc_done) w_next = S_DRAW;
      S_DRAW:  if (w_advance && w_last_col && w_last_row) w_next = S_FIN;
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cx     <= '0;
      r_cy     <= '0;
      r_base_x <= '0;
      r_base_y <= '0;
      r_color  <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && go) begin
        r_color <= color_in;
        r_cx    <= '0;
        r_cy    <= '0;
      end
      if ((r_state == S_REQ) && loc_done) begin
        r_base_x <= loc_x;
        r_base_y <= loc_y;
      end
      if (w_advance) begin
        if (w_last_col) begin
          r_cx <= '0;
          r_cy <= w_last_row ? '0 : r_cy + CW'(1);
        end else begin
          r_cx <= r_cx + CW'(1);
        end
      end
    end
  end

endmodule

`default_nettype wire
